// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Instruction/flag inputs and datapath control outputs of the
//                multicycle RV32I sequencer.
//  Revision    : 1.0
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  trigger;
    logic [DATA_WIDTH-1:0] instr;
    logic                  zero;

    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  IRWrite;
    logic                  MemWrite;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [2:0]            ALUctrl;
    logic [1:0]            ImmSrc;
    logic                  busy;
    logic                  halted;
    logic [CNT_WIDTH-1:0]  instret;

    modport master (
        output trigger, instr, zero,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, busy, halted, instret
    );

    modport slave (
        input  trigger, instr, zero,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, busy, halted, instret
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Moore sequencer for a shared-ALU, single-memory RV32I
//                datapath with a saturating retired-instruction counter.
//  Revision    : 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter bit AUTO_START = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    multicycle_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        c_IDLE     = 4'd0,
        c_FETCH    = 4'd1,
        c_DECODE   = 4'd2,
        c_MEMADR   = 4'd3,
        c_MEMREAD  = 4'd4,
        c_MEMWB    = 4'd5,
        c_MEMWRITE = 4'd6,
        c_EXECR    = 4'd7,
        c_EXECI    = 4'd8,
        c_ALUWB    = 4'd9,
        c_BRANCH   = 4'd10,
        c_JAL      = 4'd11,
        c_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_WIDTH-1:0]  r_instret;

    logic [DATA_WIDTH-1:0] w_instr;
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic                  w_funct3_ok;
    logic [2:0]            w_alu_dec;
    logic                  w_unused_instr;

    logic                  w_pcwrite;
    logic                  w_adrsrc;
    logic                  w_irwrite;
    logic                  w_memwrite;
    logic                  w_regwrite;
    logic [1:0]            w_resultsrc;
    logic [1:0]            w_alusrca;
    logic [1:0]            w_alusrcb;
    logic [2:0]            w_aluctrl;
    logic [1:0]            w_immsrc;
    logic                  w_retire;

    assign w_instr        = bus.instr;
    assign w_opcode       = w_instr[6:0];
    assign w_funct3       = w_instr[14:12];
    assign w_unused_instr = ^w_instr;

    // Only add/slt/or/and are implemented for R- and I-type arithmetic
    assign w_funct3_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b010) ||
                         (w_funct3 == 3'b110) || (w_funct3 == 3'b111);

    always_comb begin
        w_alu_dec = c_ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_dec = ((w_opcode == c_OP_RTYPE) && w_instr[30]) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  w_alu_dec = c_ALU_SLT;
            3'b110:  w_alu_dec = c_ALU_OR;
            3'b111:  w_alu_dec = c_ALU_AND;
            default: w_alu_dec = c_ALU_ADD;
        endcase
    end

    always_comb begin
        w_immsrc = 2'b00;
        case (w_opcode)
            c_OP_STORE:  w_immsrc = 2'b01;
            c_OP_BRANCH: w_immsrc = 2'b10;
            c_OP_JAL:    w_immsrc = 2'b11;
            default:     w_immsrc = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pcwrite    = 1'b0;
        w_adrsrc     = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_regwrite   = 1'b0;
        w_resultsrc  = 2'b00;
        w_alusrca    = 2'b00;
        w_alusrcb    = 2'b00;
        w_aluctrl    = c_ALU_ADD;
        w_retire     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (AUTO_START || bus.trigger) w_next_state = c_FETCH;
            end
            c_FETCH: begin
                w_irwrite    = 1'b1;
                w_pcwrite    = 1'b1;
                w_alusrcb    = 2'b10;
                w_resultsrc  = 2'b10;
                w_next_state = c_DECODE;
            end
            c_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (w_opcode)
                    c_OP_LOAD, c_OP_STORE: w_next_state = c_MEMADR;
                    c_OP_RTYPE:  w_next_state = w_funct3_ok ? c_EXECR : c_HALT;
                    c_OP_ITYPE:  w_next_state = w_funct3_ok ? c_EXECI : c_HALT;
                    c_OP_BRANCH: w_next_state = (w_funct3[2:1] == 2'b00) ? c_BRANCH : c_HALT;
                    c_OP_JAL:    w_next_state = c_JAL;
                    default:     w_next_state = c_HALT;
                endcase
            end
            c_MEMADR: begin
                w_alusrca    = 2'b10;
                w_alusrcb    = 2'b01;
                w_next_state = (w_opcode == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
            end
            c_MEMREAD: begin
                w_adrsrc     = 1'b1;
                w_next_state = c_MEMWB;
            end
            c_MEMWB: begin
                w_resultsrc  = 2'b01;
                w_regwrite   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = c_FETCH;
            end
            c_MEMWRITE: begin
                w_adrsrc     = 1'b1;
                w_memwrite   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = c_FETCH;
            end
            c_EXECR: begin
                w_alusrca    = 2'b10;
                w_aluctrl    = w_alu_dec;
                w_next_state = c_ALUWB;
            end
            c_EXECI: begin
                w_alusrca    = 2'b10;
                w_alusrcb    = 2'b01;
                w_aluctrl    = w_alu_dec;
                w_next_state = c_ALUWB;
            end
            c_ALUWB: begin
                w_regwrite   = 1'b1;
                w_retire     = 1'b1;
                w_next_state = c_FETCH;
            end
            c_BRANCH: begin
                // funct3[0] selects bne, which takes the branch on !zero
                w_alusrca    = 2'b10;
                w_aluctrl    = c_ALU_SUB;
                w_pcwrite    = bus.zero ^ w_funct3[0];
                w_retire     = 1'b1;
                w_next_state = c_FETCH;
            end
            c_JAL: begin
                w_alusrca    = 2'b01;
                w_alusrcb    = 2'b10;
                w_pcwrite    = 1'b1;
                w_next_state = c_ALUWB;
            end
            c_HALT: begin
                w_next_state = c_HALT;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_retire && (r_instret != {CNT_WIDTH{1'b1}})) begin
            r_instret <= r_instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.PCWrite   = w_pcwrite;
    assign bus.AdrSrc    = w_adrsrc;
    assign bus.IRWrite   = w_irwrite;
    assign bus.MemWrite  = w_memwrite;
    assign bus.RegWrite  = w_regwrite;
    assign bus.ResultSrc = w_resultsrc;
    assign bus.ALUSrcA   = w_alusrca;
    assign bus.ALUSrcB   = w_alusrcb;
    assign bus.ALUctrl   = w_aluctrl;
    assign bus.ImmSrc    = w_immsrc;
    assign bus.busy      = (r_state != c_IDLE) && (r_state != c_HALT);
    assign bus.halted    = (r_state == c_HALT);
    assign bus.instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed bench; per-instruction phase scripts predict every
//                control output each cycle for a wide and a 2-bit counter DUT.
//  Revision    : 1.0
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        trigger;
    logic [31:0] instr;
    logic        zero;

    multicycle_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
    multicycle_ctrl_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  bus_b ();

    assign bus_a.trigger = trigger;
    assign bus_a.instr   = instr;
    assign bus_a.zero    = zero;
    assign bus_b.trigger = trigger;
    assign bus_b.instr   = instr;
    assign bus_b.zero    = zero;

    multicycle_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16), .AUTO_START(1'b0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    multicycle_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(2), .AUTO_START(1'b0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pcw, adr, irw, memw, regw;
        logic [1:0] res, sa, sb;
        logic [2:0] alu;
        logic       busy, halted, retire;
    } exp_t;

    exp_t q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   retired   = 0;
    bit   halt_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t rest_rec();
        exp_t e;
        e = '{default: 1'b0, res: 2'b00, sa: 2'b00, sb: 2'b00, alu: 3'b000};
        e.halted = halt_mode;
        return e;
    endfunction

    function automatic void push(input logic pcw, adr, irw, memw, regw,
                                 input logic [1:0] res, sa, sb,
                                 input logic [2:0] alu, input logic retire);
        exp_t e;
        e = '{pcw: pcw, adr: adr, irw: irw, memw: memw, regw: regw,
              res: res, sa: sa, sb: sb, alu: alu,
              busy: 1'b1, halted: 1'b0, retire: retire};
        q.push_back(e);
    endfunction

    function automatic logic [1:0] imm_of(input logic [31:0] ins);
        case (ins[6:0])
            7'h23:   return 2'b01;
            7'h63:   return 2'b10;
            7'h6F:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Script the cycles of one instruction; returns cycles until the next
    // FETCH, or 2 when the instruction halts the sequencer after DECODE.
    function automatic int gen(input logic [31:0] ins, input logic z);
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] aluop;
        op = ins[6:0];
        f3 = ins[14:12];
        case (f3)
            3'b000:  aluop = (op == 7'h33 && ins[30]) ? 3'b001 : 3'b000;
            3'b010:  aluop = 3'b101;
            3'b110:  aluop = 3'b011;
            3'b111:  aluop = 3'b010;
            default: aluop = 3'b000;
        endcase
        push(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        push(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
        case (op)
            7'h03: begin
                push(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
                push(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
                push(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1);
                return 5;
            end
            7'h23: begin
                push(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
                push(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
                return 4;
            end
            7'h33, 7'h13: begin
                if (!(f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111)) return 2;
                push(0, 0, 0, 0, 0, 2'b00, 2'b10, (op == 7'h33) ? 2'b00 : 2'b01, aluop, 0);
                push(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1);
                return 4;
            end
            7'h63: begin
                if (f3 > 3'b001) return 2;
                push((f3 == 3'b000) ? z : !z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1);
                return 3;
            end
            7'h6F: begin
                push(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
                push(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1);
                return 4;
            end
            default: return 2;
        endcase
    endfunction

    always @(negedge clk) begin : p_compare
        exp_t e;
        int   exp_small;
        if (q.size() > 0) e = q.pop_front();
        else              e = rest_rec();
        exp_small = (retired > 3) ? 3 : retired;
        chk("PCWrite",   32'(bus_a.PCWrite),   32'(e.pcw));
        chk("AdrSrc",    32'(bus_a.AdrSrc),    32'(e.adr));
        chk("IRWrite",   32'(bus_a.IRWrite),   32'(e.irw));
        chk("MemWrite",  32'(bus_a.MemWrite),  32'(e.memw));
        chk("RegWrite",  32'(bus_a.RegWrite),  32'(e.regw));
        chk("ResultSrc", 32'(bus_a.ResultSrc), 32'(e.res));
        chk("ALUSrcA",   32'(bus_a.ALUSrcA),   32'(e.sa));
        chk("ALUSrcB",   32'(bus_a.ALUSrcB),   32'(e.sb));
        chk("ALUctrl",   32'(bus_a.ALUctrl),   32'(e.alu));
        chk("ImmSrc",    32'(bus_a.ImmSrc),    32'(imm_of(instr)));
        chk("busy",      32'(bus_a.busy),      32'(e.busy));
        chk("halted",    32'(bus_a.halted),    32'(e.halted));
        chk("instret",   32'(bus_a.instret),   32'(retired));
        chk("busy_b",    32'(bus_b.busy),      32'(e.busy));
        chk("instret_b", 32'(bus_b.instret),   32'(exp_small));
        if (e.retire) retired++;
    end

    task automatic do_instr(input logic [31:0] ins, input logic z, input bit first, input int exp_len);
        int n;
        instr = ins;
        zero  = z;
        if (first) begin
            trigger = 1'b1;
            q.push_back(rest_rec());
        end
        n = gen(ins, z);
        chk("latency", 32'(n), 32'(exp_len));
        if (first) begin
            @(posedge clk); #2;
            trigger = 1'b0;
        end
        repeat (n) begin
            @(posedge clk); #2;
        end
        if (n == 2) halt_mode = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        retired   = 0;
        halt_mode = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        trigger = 1'b0;
        instr   = 32'h0;
        zero    = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #2; end
        chk("idle_busy",     32'(bus_a.busy),     32'd0);
        chk("idle_regwrite", 32'(bus_a.RegWrite), 32'd0);
        chk("idle_instret",  32'(bus_a.instret),  32'd0);

        // addi, then an illegal opcode
        do_instr(32'h00500513, 1'b0, 1'b1, 4);
        chk("addi_instret", 32'(bus_a.instret), 32'd1);
        do_instr(32'h0000007F, 1'b0, 1'b0, 2);
        repeat (2) begin
            trigger = 1'b1; @(posedge clk); #2;
            trigger = 1'b0; @(posedge clk); #2;
        end
        chk("halt_sticky", 32'(bus_a.halted), 32'd1);
        do_reset();

        // memory, branch, ALU and jump mix
        do_instr(32'h00002283, 1'b0, 1'b1, 5);
        do_instr(32'h00502023, 1'b0, 1'b0, 4);
        do_instr(32'h00000063, 1'b1, 1'b0, 3);
        do_instr(32'h00001063, 1'b1, 1'b0, 3);
        do_instr(32'h40B50533, 1'b0, 1'b0, 4);
        chk("five_instret_a", 32'(bus_a.instret), 32'd5);
        chk("five_instret_b", 32'(bus_b.instret), 32'd3);
        do_instr(32'h0080006F, 1'b0, 1'b0, 4);
        do_instr(32'h00B56533, 1'b0, 1'b0, 4);
        do_instr(32'h00A52513, 1'b0, 1'b0, 4);
        do_instr(32'h0FF57513, 1'b0, 1'b0, 4);
        do_instr(32'h00000063, 1'b0, 1'b0, 3);
        do_instr(32'h00001063, 1'b0, 1'b0, 3);
        do_instr(32'h00B51533, 1'b0, 1'b0, 2);
        @(posedge clk); #2;
        chk("mix_instret_a", 32'(bus_a.instret), 32'd11);
        chk("mix_instret_b", 32'(bus_b.instret), 32'd3);
        chk("mix_halted",    32'(bus_a.halted),  32'd1);
        do_reset();

        // asynchronous reset while a store is in MEMWRITE
        do_instr(32'h00500513, 1'b0, 1'b1, 4);
        instr = 32'h00502023;
        n = gen(instr, 1'b0);
        chk("sw_latency", 32'(n), 32'd4);
        repeat (3) begin @(posedge clk); #2; end
        chk("pre_rst_memwrite", 32'(bus_a.MemWrite), 32'd1);
        chk("pre_rst_instret",  32'(bus_a.instret),  32'd1);
        rst = 1'b1;
        q.delete();
        retired   = 0;
        halt_mode = 1'b0;
        #1;
        chk("async_memwrite", 32'(bus_a.MemWrite), 32'd0);
        chk("async_instret",  32'(bus_a.instret),  32'd0);
        chk("async_busy",     32'(bus_a.busy),     32'd0);
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #2; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
